dsp_mul_arbiter: RTL and testbench

Shares one pipelined DSP_mul instance (fixed latency LAT) among NREQ requesters, e.g. the Montgomery/Fp sequencers in the BN254 datapath.
- Round-robin arbitration, at most one issue per cycle.
- Request IDs travel alongside the DSP pipeline in a tag shift register.
- Products are buffered in a credit-protected response FIFO, so downstream backpressure never drops an in-flight result.

---
 rtl/dsp_mul_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dsp_mul_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mul_arbiter.sv
// dsp_mul_arbiter: shares one pipelined DSP multiplier (fixed latency LAT) among NREQ
// requesters. Round-robin grant, one issue per cycle. Request IDs ride a tag shift
// register alongside the DSP pipeline. Products land in a credit-protected
// first-word-fall-through FIFO, so downstream backpressure never drops a result.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake; req_ready is a one-hot grant
//   req_a, req_b            packed operands, requester i at [i*AW +: AW] / [i*BW +: BW]
//   mul_a, mul_b            registered operands to the DSP multiplier
//   mul_p                   DSP multiplier product
//   rsp_valid/rsp_ready     response handshake at the FIFO head
//   rsp_id, rsp_data        requester index and product of the head entry (0 when empty)
//   busy                    any request in flight or buffered
//
// Optional feature (macro DSP_ARB_PERF_EN): adds saturating 32-bit counters
//   perf_issue (handshakes) and perf_stall (cycles with a request but no credit).

module dsp_mul_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned LAT    = 3,
  parameter int unsigned AW     = 27,
  parameter int unsigned BW     = 18,
  parameter int unsigned PW     = 48,
  parameter int unsigned FIFO_D = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*AW-1:0]      req_a,
  input  logic [NREQ*BW-1:0]      req_b,
  output logic [AW-1:0]           mul_a,
  output logic [BW-1:0]           mul_b,
  input  logic [PW-1:0]           mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [PW-1:0]           rsp_data,
  output logic                    busy
`ifdef DSP_ARB_PERF_EN
  ,
  output logic [31:0]             perf_issue,
  output logic [31:0]             perf_stall
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);
  // Wide enough for inflight + fifo_cnt at their joint maximum.
  localparam int unsigned CW  = $clog2(FIFO_D + LAT + 2);
  localparam int unsigned FAW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

  if (FIFO_D < LAT + 2) begin : g_cfg_err
    $error("dsp_mul_arbiter: FIFO_D must be >= LAT+2");
  end

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic           credit_ok;
  logic           issue;
  logic [AW-1:0]  gnt_a;
  logic [BW-1:0]  gnt_b;

  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [LAT:0]   tag_v_q;
  logic [IDW-1:0] tag_id_q [LAT+1];

  logic [IDW-1:0] mem_id   [FIFO_D];
  logic [PW-1:0]  mem_data [FIFO_D];
  logic [FAW-1:0] wr_ptr_q, rd_ptr_q;
  logic           fifo_wr;
  logic           fifo_pop;

  // ---------------------------------------------------------------------------
  // Round-robin scan starting at ptr_q. Descending offsets so the smallest
  // offset (closest to ptr_q) is the last assignment and wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [IDW:0] scan;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) begin
        scan = scan - (IDW+1)'(NREQ);
      end
      if (req_valid[scan[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[IDW-1:0];
      end
    end
  end

  assign credit_ok = (inflight_q + fifo_cnt_q) < CW'(FIFO_D);
  // rst_n gating keeps req_ready low while reset is held, even with requests pending.
  assign issue     = rst_n & credit_ok & gnt_found;
  assign req_ready = issue ? (NREQ'(1) << gnt_idx) : '0;

  assign gnt_a = req_a[int'(gnt_idx) * AW +: AW];
  assign gnt_b = req_b[int'(gnt_idx) * BW +: BW];

  // ---------------------------------------------------------------------------
  // Issue stage and round-robin pointer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (issue) begin
      ptr_q <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      mul_a <= gnt_a;
      mul_b <= gnt_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipe: stage 0 lines up with mul_a/mul_b, stage LAT with mul_p.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      for (int k = 0; k <= LAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      tag_v_q     <= {tag_v_q[LAT-1:0], issue};
      tag_id_q[0] <= gnt_idx;
      for (int k = 1; k <= LAT; k++) begin
        tag_id_q[k] <= tag_id_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO (first-word-fall-through) and credit counters.
  // ---------------------------------------------------------------------------
  assign fifo_wr   = tag_v_q[LAT];
  assign rsp_valid = (fifo_cnt_q != '0);
  assign fifo_pop  = rsp_valid & rsp_ready;

  always_comb begin
    inflight_d = inflight_q + CW'(issue) - CW'(fifo_wr);
    fifo_cnt_d = fifo_cnt_q + CW'(fifo_wr) - CW'(fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_id[wr_ptr_q]   <= tag_id_q[LAT];
      mem_data[wr_ptr_q] <= mul_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (fifo_wr) begin
        wr_ptr_q <= (wr_ptr_q == FAW'(FIFO_D - 1)) ? '0 : wr_ptr_q + FAW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= (rd_ptr_q == FAW'(FIFO_D - 1)) ? '0 : rd_ptr_q + FAW'(1);
      end
    end
  end

  assign rsp_id   = rsp_valid ? mem_id[rd_ptr_q]   : '0;
  assign rsp_data = rsp_valid ? mem_data[rd_ptr_q] : '0;
  assign busy     = (inflight_q != '0) | (fifo_cnt_q != '0);

`ifdef DSP_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  logic stall_cyc;
  assign stall_cyc = (|req_valid) & ~credit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (issue && (perf_issue != 32'hFFFF_FFFF)) begin
        perf_issue <= perf_issue + 32'd1;
      end
      if (stall_cyc && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Self-checking bench for dsp_mul_arbiter. A behavioural DSP multiplier (LAT-deep
// product pipe) is attached to mul_a/mul_b/mul_p. The reference model is a plain
// transaction queue: each handshake pushes {id, a*b, cycle it becomes visible}, the
// credit is "issued but not yet popped < FIFO_D", and the grant is the first valid
// requester from a round-robin pointer. Directed phases add literal expectations.

module tb_dsp_mul_arbiter;

  localparam int NREQ   = 4;
  localparam int LAT    = 3;
  localparam int AW     = 27;
  localparam int BW     = 18;
  localparam int PW     = 48;
  localparam int FIFO_D = 8;
  localparam int IDW    = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_a;
  logic [NREQ*BW-1:0]   req_b;
  logic [AW-1:0]        mul_a;
  logic [BW-1:0]        mul_b;
  logic [PW-1:0]        mul_p;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [PW-1:0]        rsp_data;
  logic                 busy;
`ifdef DSP_ARB_PERF_EN
  logic [31:0]          perf_issue;
  logic [31:0]          perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsp_mul_arbiter #(
    .NREQ  (NREQ),
    .LAT   (LAT),
    .AW    (AW),
    .BW    (BW),
    .PW    (PW),
    .FIFO_D(FIFO_D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
`ifdef DSP_ARB_PERF_EN
    ,
    .perf_issue(perf_issue),
    .perf_stall(perf_stall)
`endif
  );

  // Behavioural DSP multiplier: product of the operands seen LAT cycles earlier.
  logic [PW-1:0] p_pipe [LAT];
  initial for (int k = 0; k < LAT; k++) p_pipe[k] = '0;
  always @(posedge clk) begin
    p_pipe[0] <= PW'(mul_a) * PW'(mul_b);
    for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mul_p = p_pipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare (outputs sampled at negedge).
  // ---------------------------------------------------------------------------
  typedef struct {
    int              id;
    longint unsigned p;
    int              rdy;
  } rsp_t;

  rsp_t            mq[$];
  int              m_ptr = 0;
  int              m_out = 0;
  int              m_issue = 0;
  int              m_stall = 0;
  int              cyc = 0;
  logic [AW-1:0]   m_a = '0;
  logic [BW-1:0]   m_b = '0;

  always @(negedge clk) begin : cmp_p
    int              g;
    int              idx;
    logic            vis;
    logic [NREQ-1:0] exp_rdy;
    longint unsigned pa, pb;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id",    64'(rsp_id),    64'd0);
      chk("rst_rsp_data",  64'(rsp_data),  64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_mul_a",     64'(mul_a),     64'd0);
      chk("rst_mul_b",     64'(mul_b),     64'd0);
`ifdef DSP_ARB_PERF_EN
      chk("rst_perf_issue", 64'(perf_issue), 64'd0);
      chk("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
      mq.delete();
      m_ptr = 0; m_out = 0; m_issue = 0; m_stall = 0; m_a = '0; m_b = '0;
    end else begin
      g = -1;
      if (m_out < FIFO_D) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
      vis = 1'b0;
      if (mq.size() > 0) vis = (mq[0].rdy <= cyc);

      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(vis));
      chk("rsp_id",    64'(rsp_id),    vis ? 64'(mq[0].id) : 64'd0);
      chk("rsp_data",  64'(rsp_data),  vis ? mq[0].p : 64'd0);
      chk("busy",      64'(busy),      64'(m_out != 0));
      chk("mul_a",     64'(mul_a),     64'(m_a));
      chk("mul_b",     64'(mul_b),     64'(m_b));
`ifdef DSP_ARB_PERF_EN
      chk("perf_issue", 64'(perf_issue), 64'(m_issue));
      chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif

      if (req_valid != '0 && m_out >= FIFO_D) m_stall++;
      if (g >= 0) begin
        m_a = req_a[g*AW +: AW];
        m_b = req_b[g*BW +: BW];
        pa  = 64'(m_a);
        pb  = 64'(m_b);
        mq.push_back('{id: g, p: pa * pb, rdy: cyc + LAT + 2});
        m_ptr = (g + 1) % NREQ;
        m_out++;
        m_issue++;
      end
      if (vis && rsp_ready) begin
        void'(mq.pop_front());
        m_out--;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus. Inputs change 1 time unit after posedge; checks happen at negedge.
  // ---------------------------------------------------------------------------
  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 100; n++) begin
      cyc_begin();
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      if (!busy) break;
    end
    chk(nm, 64'(busy), 64'd0);
  endtask

  task automatic pulse_reset();
    cyc_begin();
    req_valid = '0;
    rst_n = 1'b0;
    cyc_begin();
    rst_n = 1'b1;
  endtask

  initial begin
    int hs_cnt;
    int seen;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    cyc_begin();
    rst_n = 1'b1;

    // Single request, 3*5, visible LAT+2 cycles after the handshake.
    cyc_begin();
    req_valid = 4'b0001;
    req_a[0 +: AW] = AW'(3);
    req_b[0 +: BW] = BW'(5);
    @(negedge clk);
    chk("single_grant", 64'(req_ready), 64'b0001);
    for (int k = 1; k <= 6; k++) begin
      cyc_begin();
      req_valid = '0;
      @(negedge clk);
      if (k == 4) chk("single_not_early", 64'(rsp_valid), 64'd0);
      if (k == 5) begin
        chk("single_valid", 64'(rsp_valid), 64'd1);
        chk("single_id",    64'(rsp_id),    64'd0);
        chk("single_data",  64'(rsp_data),  64'd15);
      end
      if (k == 6) chk("single_idle", 64'(busy), 64'd0);
    end

    // All requesters streaming; pointer is 1 after the single grant to requester 0.
    for (int k = 0; k < 12; k++) begin
      cyc_begin();
      req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*AW +: AW] = AW'($urandom());
        req_b[i*BW +: BW] = BW'($urandom());
      end
      @(negedge clk);
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << ((1 + k) % NREQ)));
    end
    drain("rr_drain");

    // Maximum operands from requester 2.
    cyc_begin();
    req_valid = 4'b0100;
    req_a[2*AW +: AW] = {AW{1'b1}};
    req_b[2*BW +: BW] = {BW{1'b1}};
    seen = 0;
    for (int k = 0; k < 12 && seen == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        chk("max_id",   64'(rsp_id),   64'd2);
        chk("max_data", 64'(rsp_data), 64'h1FFFF7FC0001);
      end
      cyc_begin();
      req_valid = '0;
    end
    chk("max_seen", 64'(seen), 64'd1);
    drain("max_drain");

    // Backpressure: requester 1 streams with rsp_ready low.
    pulse_reset();
    hs_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc_begin();
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      req_a[1*AW +: AW] = AW'($urandom());
      req_b[1*BW +: BW] = BW'($urandom());
      @(negedge clk);
      if (req_ready[1]) hs_cnt++;
    end
    chk("bp_hs_count", 64'(hs_cnt), 64'(FIFO_D));
    chk("bp_ready_low", 64'(req_ready), 64'd0);
`ifdef DSP_ARB_PERF_EN
    chk("bp_perf_issue", 64'(perf_issue), 64'(FIFO_D));
`endif
    cyc_begin();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_pop", 64'(rsp_valid), 64'd1);
    chk("bp_blocked_at_pop", 64'(req_ready), 64'd0);
    cyc_begin();
    @(negedge clk);
    chk("bp_resume", 64'(req_ready), 64'b0010);
    repeat (6) begin
      cyc_begin();
      req_a[1*AW +: AW] = AW'($urandom());
      @(negedge clk);
    end
    drain("bp_drain");

    // Reset mid-flight: two issues land, the third cycle is taken by reset.
    cyc_begin();
    req_valid = 4'b0111;
    rsp_ready = 1'b1;
    cyc_begin();
    cyc_begin();
    rst_n = 1'b0;
    cyc_begin();
    rst_n = 1'b1;
    req_valid = '0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      cyc_begin();
    end
    chk("rst_flight_no_rsp", 64'(seen), 64'd0);
    req_valid = 4'b1111;
    @(negedge clk);
    chk("post_rst_grant", 64'(req_ready), 64'b0001);

    // Randomized traffic with bursts of heavy backpressure.
    for (int k = 0; k < 800; k++) begin
      cyc_begin();
      req_valid = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? {AW{1'b1}} : AW'($urandom());
        req_b[i*BW +: BW] = ($urandom_range(0, 7) == 0) ? {BW{1'b1}} : BW'($urandom());
      end
      if ((k / 100) % 2 == 1) rsp_ready = ($urandom_range(0, 3) == 0);
      else                    rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
